onehot_to_bin_pipe: RTL and testbench

//   Registered, parametrised successor of the 16-bit one-hot to binary encoder in the pooling datapath.

---
 rtl/onehot_to_bin_pipe_pkg.sv | 28 ++
 rtl/onehot_to_bin_pipe_if.sv | 38 +++
 rtl/onehot_to_bin_pipe_encode_core.sv | 42 ++++
 rtl/onehot_to_bin_pipe.sv | 95 +++++++++
 tb/tb_onehot_to_bin_pipe.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/onehot_to_bin_pipe_pkg.sv
// ============================================================================
// onehot_pkg : shared types and helpers for the one-hot to binary pipe
// Rev 1.0
// ============================================================================
`default_nettype none

package onehot_pkg;

  // Widest index any instance may produce; narrower instances zero-extend.
  localparam int BIN_W_MAX = 16;

  localparam int ERR_CNT_W_DEF = 8;
  localparam logic [ERR_CNT_W_DEF-1:0] ERR_SAT = {ERR_CNT_W_DEF{1'b1}};

  // $clog2(2) is 1 but $clog2(1) is 0; keep the index at least one bit wide.
  function automatic int bin_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  typedef struct packed {
    logic [BIN_W_MAX-1:0] bin;
    logic                 zero;
    logic                 multi;
  } enc_res_t;

endpackage

`default_nettype wire

// File: rtl/onehot_to_bin_pipe_if.sv
// ============================================================================
// onehot_to_bin_pipe_if : input/output handshake and error-counter bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface onehot_to_bin_pipe_if
  import onehot_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ERR_CNT_W = 8
);
  localparam int BIN_W = bin_width(WIDTH);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_onehot;
  logic                 out_valid;
  logic                 out_ready;
  logic [BIN_W-1:0]     out_bin;
  logic                 out_zero;
  logic                 out_multi;
  logic                 clr_err;
  logic [ERR_CNT_W-1:0] err_count;

  modport slave (
    input  in_valid, in_onehot, out_ready, clr_err,
    output in_ready, out_valid, out_bin, out_zero, out_multi, err_count
  );

  modport master (
    output in_valid, in_onehot, out_ready, clr_err,
    input  in_ready, out_valid, out_bin, out_zero, out_multi, err_count
  );

endinterface

`default_nettype wire

// File: rtl/onehot_to_bin_pipe_encode_core.sv
// ============================================================================
// onehot_encode_core : combinational lowest-set-bit index with zero/multi flags
// Rev 1.0
// ============================================================================
`default_nettype none

module onehot_encode_core
  import onehot_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int PRIORITY_MODE = 0
) (
  input  logic [WIDTH-1:0] onehot_i,
  output enc_res_t         res_o
);
  localparam int BIN_W = bin_width(WIDTH);

  logic [BIN_W-1:0] w_idx;
  logic [WIDTH-1:0] w_less_one;
  logic             w_multi;

  // Scanning downward lets the lowest set bit overwrite any higher hit.
  always_comb begin
    w_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (onehot_i[i]) w_idx = BIN_W'(i);
    end
  end

  assign w_less_one = onehot_i - WIDTH'(1);
  assign w_multi    = |(onehot_i & w_less_one);

  always_comb begin
    res_o       = '0;
    res_o.bin   = BIN_W_MAX'(w_idx);
    res_o.zero  = ~|onehot_i;
    res_o.multi = (PRIORITY_MODE == 0) && w_multi;
  end

endmodule

`default_nettype wire

// File: rtl/onehot_to_bin_pipe.sv
// ============================================================================
// onehot_to_bin_pipe : registered one-hot to binary encoder, valid/ready both
//                      sides, saturating count of illegal words
// Rev 1.0
// ============================================================================
`default_nettype none

module onehot_to_bin_pipe
  import onehot_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int PRIORITY_MODE = 0,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  onehot_to_bin_pipe_if.slave  bus
);
  localparam int BIN_W = bin_width(WIDTH);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

  enc_res_t             w_res;
  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_err_event;

  logic                 valid_q, valid_d;
  logic [BIN_W-1:0]     bin_q,   bin_d;
  logic                 zero_q,  zero_d;
  logic                 multi_q, multi_d;
  logic [ERR_CNT_W-1:0] err_q,   err_d;

  onehot_encode_core #(
    .WIDTH         (WIDTH),
    .PRIORITY_MODE (PRIORITY_MODE)
  ) u_core (
    .onehot_i (bus.in_onehot),
    .res_o    (w_res)
  );

  assign w_in_ready  = !valid_q || bus.out_ready;
  assign w_accept    = bus.in_valid && w_in_ready;
  // The core already suppresses multi in priority mode.
  assign w_err_event = w_accept && (w_res.zero || w_res.multi);

  always_comb begin
    valid_d = valid_q;
    bin_d   = bin_q;
    zero_d  = zero_q;
    multi_d = multi_q;
    if (w_accept) begin
      valid_d = 1'b1;
      bin_d   = BIN_W'(w_res.bin);
      zero_d  = w_res.zero;
      multi_d = w_res.multi;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    err_d = err_q;
    if (bus.clr_err) begin
      err_d = '0;
    end else if (w_err_event && (err_q != ERR_MAX)) begin
      err_d = err_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      bin_q   <= '0;
      zero_q  <= 1'b0;
      multi_q <= 1'b0;
      err_q   <= '0;
    end else begin
      valid_q <= valid_d;
      bin_q   <= bin_d;
      zero_q  <= zero_d;
      multi_q <= multi_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_bin   = bin_q;
  assign bus.out_zero  = zero_q;
  assign bus.out_multi = multi_q;
  assign bus.err_count = err_q;

endmodule

`default_nettype wire

// File: tb/tb_onehot_to_bin_pipe.sv
// ============================================================================
// tb_onehot_to_bin_pipe : three instances (strict/8-bit, priority/8-bit,
//                         strict/2-bit counter) driven with identical traffic
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_onehot_to_bin_pipe;

  typedef struct {
    int bin;
    bit zero;
    bit multi;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        d_valid = 1'b0;
  logic        d_ready = 1'b1;
  logic        d_clr = 1'b0;
  logic [15:0] d_onehot = 16'h0000;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  bit   m_valid = 1'b0;
  int   m_err0 = 0;
  int   m_err1 = 0;
  int   m_err2 = 0;

  always #5 clk = ~clk;

  onehot_to_bin_pipe_if #(.WIDTH(16), .ERR_CNT_W(8)) if0 ();
  onehot_to_bin_pipe_if #(.WIDTH(16), .ERR_CNT_W(8)) if1 ();
  onehot_to_bin_pipe_if #(.WIDTH(16), .ERR_CNT_W(2)) if2 ();

  assign if0.in_valid = d_valid;  assign if0.in_onehot = d_onehot;
  assign if0.out_ready = d_ready; assign if0.clr_err = d_clr;
  assign if1.in_valid = d_valid;  assign if1.in_onehot = d_onehot;
  assign if1.out_ready = d_ready; assign if1.clr_err = d_clr;
  assign if2.in_valid = d_valid;  assign if2.in_onehot = d_onehot;
  assign if2.out_ready = d_ready; assign if2.clr_err = d_clr;

  onehot_to_bin_pipe #(.WIDTH(16), .PRIORITY_MODE(0), .ERR_CNT_W(8))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  onehot_to_bin_pipe #(.WIDTH(16), .PRIORITY_MODE(1), .ERR_CNT_W(8))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  onehot_to_bin_pipe #(.WIDTH(16), .PRIORITY_MODE(0), .ERR_CNT_W(2))
    dut2 (.clk(clk), .rst(rst), .bus(if2));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Isolate the lowest set bit arithmetically; its log2 is the index.
  function automatic int lowest_index(input logic [15:0] w);
    logic [15:0] iso;
    iso = w & (~w + 16'd1);
    return (w == 16'h0000) ? 0 : $clog2(iso);
  endfunction

  // Reference model: what each edge should do, from the handshake rules.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0;
      q.delete();
      m_err0 = 0;
      m_err1 = 0;
      m_err2 = 0;
    end else begin
      bit   acc;
      int   n;
      exp_t e;
      n   = $countones(d_onehot);
      acc = d_valid && (!m_valid || d_ready);
      if (acc) begin
        e.bin   = lowest_index(d_onehot);
        e.zero  = (n == 0);
        e.multi = (n > 1);
        q.push_back(e);
      end
      m_valid = acc || (m_valid && !d_ready);
      if (d_clr) begin
        m_err0 = 0; m_err1 = 0; m_err2 = 0;
      end else if (acc) begin
        if (n != 1 && m_err0 < 255) m_err0++;
        if (n == 0 && m_err1 < 255) m_err1++;
        if (n != 1 && m_err2 < 3)   m_err2++;
      end
    end
  end

  // Monitor: mid-cycle, compare presented outputs with the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", int'(if0.in_ready), int'(!m_valid || d_ready));
      chk("out_valid0", int'(if0.out_valid), int'(m_valid));
      chk("out_valid1", int'(if1.out_valid), int'(m_valid));
      chk("out_valid2", int'(if2.out_valid), int'(m_valid));
      chk("err_count0", int'(if0.err_count), m_err0);
      chk("err_count1", int'(if1.err_count), m_err1);
      chk("err_count2", int'(if2.err_count), m_err2);
      if (if0.out_valid) begin
        chk("scoreboard_nonempty", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          exp_t e;
          e = q[0];
          chk("out_bin0", int'(if0.out_bin), e.bin);
          chk("out_bin1", int'(if1.out_bin), e.bin);
          chk("out_bin2", int'(if2.out_bin), e.bin);
          chk("out_zero0", int'(if0.out_zero), int'(e.zero));
          chk("out_zero1", int'(if1.out_zero), int'(e.zero));
          chk("out_multi0", int'(if0.out_multi), int'(e.multi));
          chk("out_multi1", int'(if1.out_multi), 0);
          chk("out_multi2", int'(if2.out_multi), int'(e.multi));
          if (d_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [15:0] w);
    d_valid  = 1'b1;
    d_onehot = w;
    step();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid0"}, int'(if0.out_valid), 0);
    chk({tag, "_valid2"}, int'(if2.out_valid), 0);
    chk({tag, "_bin0"},   int'(if0.out_bin), 0);
    chk({tag, "_zero0"},  int'(if0.out_zero), 0);
    chk({tag, "_multi0"}, int'(if0.out_multi), 0);
    chk({tag, "_err0"},   int'(if0.err_count), 0);
    chk({tag, "_err2"},   int'(if2.err_count), 0);
  endtask

  initial begin
    repeat (3) step();
    check_reset_state("reset");
    rst = 1'b0;
    step();

    // Walking one, back-to-back
    for (int i = 0; i < 16; i++) send(16'h0001 << i);
    // Zero-hot, strict multi-hot, multi-hot with distinct priority answer
    send(16'h0000);
    send(16'h0120);
    send(16'h8006);
    d_valid = 1'b0;
    step();

    // Backpressure with a pending word behind the stalled one
    send(16'h0040);
    d_ready  = 1'b0;
    d_onehot = 16'h0200;
    repeat (3) step();
    d_ready = 1'b1;
    step();
    d_valid = 1'b0;
    step();

    // Saturation of the narrow counter, then clear racing an error word
    for (int i = 0; i < 5; i++) send(16'h0000);
    d_clr = 1'b1;
    send(16'h0000);
    d_clr = 1'b0;
    d_valid = 1'b0;
    step();
    step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      d_valid = ($urandom % 4) != 0;
      d_ready = ($urandom % 4) != 0;
      d_clr   = ($urandom % 32) == 0;
      r = int'($urandom % 8);
      if (r == 0)      d_onehot = 16'h0000;
      else if (r == 1) d_onehot = 16'($urandom);
      else             d_onehot = 16'h0001 << ($urandom % 16);
      step();
    end
    d_clr   = 1'b0;
    d_valid = 1'b0;
    d_ready = 1'b1;
    repeat (2) step();

    // Async reset while an illegal word is stalled at the output
    d_ready = 1'b0;
    send(16'h0000);
    d_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check_reset_state("async_reset");
    repeat (2) step();
    rst = 1'b0;
    d_ready = 1'b1;
    send(16'h1000);
    d_valid = 1'b0;
    #1;
    chk("post_reset_bin", int'(if0.out_bin), 12);
    repeat (3) step();

    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
